// File: rtl/acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : acc_unit
// Purpose  : Parametrised working accumulator for the CPU datapath. Supports
//            clear, load, increment, decrement and logical shifts with
//            optional saturation, registered carry/overflow flags and a LIFO
//            save stack for nested context save/restore of the accumulator.
// Ports    : clk, rst (sync, active-high)
//            clr/load/pop/inc/dec/shl/shr : op requests, priority in that order
//            push                         : save pre-update ac_out to stack
//            alu_result [WIDTH]           : load data
//            ac_out [WIDTH], zero, neg    : accumulator and its decodes
//            carry, ovf                   : flags of the last executed op
//            stack_full, stack_empty      : stack occupancy status
//            stack_err                    : one-cycle pulse after bad request
// Revision : 1.0 - initial release
// ============================================================================
module acc_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  parameter bit SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             pop,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             push,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] ac_out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(STACK_DEPTH);
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [0:STACK_DEPTH-1];

  logic          w_full, w_empty;
  logic          w_pop_sel;   // pop is the selected op (not shadowed)
  logic          w_do_push, w_do_pop;
  logic [CW-1:0] w_rd_cnt;
  logic [IW-1:0] w_wr_idx, w_rd_idx;

  assign w_full    = (cnt_q == DEPTH_C);
  assign w_empty   = (cnt_q == '0);
  assign w_pop_sel = pop & ~clr & ~load;

  // Simultaneous push/pop is always illegal, so any push with pop is dropped.
  assign w_do_push = push & ~pop & ~w_full;
  assign w_do_pop  = w_pop_sel & ~push & ~w_empty;
  assign err_d     = (push & pop) | (w_pop_sel & w_empty) | (push & ~pop & w_full);

  assign w_rd_cnt  = cnt_q - 1'b1;
  assign w_wr_idx  = cnt_q[IW-1:0];
  assign w_rd_idx  = w_rd_cnt[IW-1:0];

  always_comb begin
    ac_d    = ac_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (clr) begin
      ac_d    = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (load) begin
      ac_d    = alu_result;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (pop) begin
      // A rejected pop still claims the op slot; everything holds.
      if (w_do_pop) begin
        ac_d    = mem_q[w_rd_idx];
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (inc) begin
      carry_d = (ac_q == ONES);
      ovf_d   = (ac_q == MAX_POS);
      ac_d    = (SATURATE && ac_q == ONES) ? ONES : ac_q + 1'b1;
    end else if (dec) begin
      carry_d = (ac_q == '0);
      ovf_d   = (ac_q == MIN_NEG);
      ac_d    = (SATURATE && ac_q == '0) ? '0 : ac_q - 1'b1;
    end else if (shl) begin
      carry_d = ac_q[WIDTH-1];
      ovf_d   = ac_q[WIDTH-1] ^ ac_q[WIDTH-2];
      ac_d    = {ac_q[WIDTH-2:0], 1'b0};
    end else if (shr) begin
      carry_d = ac_q[0];
      ovf_d   = 1'b0;
      ac_d    = {1'b0, ac_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_do_push)
      cnt_d = cnt_q + 1'b1;
    else if (w_do_pop)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ac_q    <= ac_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack storage is not reset; entries are unreachable while empty.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push)
      mem_q[w_wr_idx] <= ac_q;
  end

  assign ac_out      = ac_q;
  assign zero        = (ac_q == '0);
  assign neg         = ac_q[WIDTH-1];
  assign carry       = carry_q;
  assign ovf         = ovf_q;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_unit
// Purpose  : Self-checking bench for acc_unit. A wrapping and a saturating
//            instance share the same stimulus; a vector table drives one
//            request set per cycle and lists the expected registered state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_unit;

  localparam logic [8:0] R  = 9'h100;
  localparam logic [8:0] CL = 9'h080;
  localparam logic [8:0] LD = 9'h040;
  localparam logic [8:0] PO = 9'h020;
  localparam logic [8:0] IN = 9'h010;
  localparam logic [8:0] DE = 9'h008;
  localparam logic [8:0] SL = 9'h004;
  localparam logic [8:0] SR = 9'h002;
  localparam logic [8:0] PU = 9'h001;
  localparam logic [8:0] NO = 9'h000;

  typedef struct {
    logic [8:0]  op;
    logic [15:0] alu;
    logic [15:0] ac;
    logic        c, o, z, n, f, e, err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, clr, load, pop, inc, dec, shl, shr, push;
  logic [15:0] alu_result;

  logic [15:0] ac_w, ac_s;
  logic        z_w, n_w, c_w, o_w, f_w, e_w, err_w;
  logic        z_s, n_s, c_s, o_s, f_s, e_s, err_s;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  acc_unit #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .pop(pop), .inc(inc),
    .dec(dec), .shl(shl), .shr(shr), .push(push), .alu_result(alu_result),
    .ac_out(ac_w), .zero(z_w), .neg(n_w), .carry(c_w), .ovf(o_w),
    .stack_full(f_w), .stack_empty(e_w), .stack_err(err_w)
  );

  acc_unit #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .pop(pop), .inc(inc),
    .dec(dec), .shl(shl), .shr(shr), .push(push), .alu_result(alu_result),
    .ac_out(ac_s), .zero(z_s), .neg(n_s), .carry(c_s), .ovf(o_s),
    .stack_full(f_s), .stack_empty(e_s), .stack_err(err_s)
  );

  task automatic add(input logic [8:0] op, input logic [15:0] alu,
                     input logic [15:0] ac, input logic c, input logic o,
                     input logic z, input logic n, input logic f,
                     input logic e, input logic err);
    vec_t v;
    v.op = op; v.alu = alu; v.ac = ac; v.c = c; v.o = o; v.z = z;
    v.n = n; v.f = f; v.e = e; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [8:0] op, input logic [15:0] alu);
    {rst, clr, load, pop, inc, dec, shl, shr, push} = op;
    alu_result = alu;
  endtask

  // Apply current inputs across one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    drive(NO, 16'h0000);

    //   op          alu      ac       c  o  z  n  f  e  err
    add(R | LD,     16'h1234, 16'h0000, 0, 0, 1, 0, 0, 1, 0);
    add(LD,         16'h8000, 16'h8000, 0, 0, 0, 1, 0, 1, 0);
    add(LD,         16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 0, 1, 0);
    add(IN,         16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1, 0);
    add(LD,         16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 1, 0);
    add(IN,         16'h0000, 16'h8000, 0, 1, 0, 1, 0, 1, 0);
    add(LD,         16'hC001, 16'hC001, 0, 0, 0, 1, 0, 1, 0);
    add(SL,         16'h0000, 16'h8002, 1, 0, 0, 1, 0, 1, 0);
    add(SR,         16'h0000, 16'h4001, 0, 0, 0, 0, 0, 1, 0);
    add(CL|LD|IN,   16'h1234, 16'h0000, 0, 0, 1, 0, 0, 1, 0);
    add(DE,         16'h0000, 16'hFFFF, 1, 0, 0, 1, 0, 1, 0);
    add(LD,         16'h8000, 16'h8000, 0, 0, 0, 1, 0, 1, 0);
    add(DE,         16'h0000, 16'h7FFF, 0, 1, 0, 0, 0, 1, 0);
    // stack fill: pushes save the pre-load value
    add(LD,         16'h0001, 16'h0001, 0, 0, 0, 0, 0, 1, 0);
    add(PU | LD,    16'h0002, 16'h0002, 0, 0, 0, 0, 0, 0, 0);
    add(PU | LD,    16'h0003, 16'h0003, 0, 0, 0, 0, 0, 0, 0);
    add(PU | LD,    16'h0004, 16'h0004, 0, 0, 0, 0, 0, 0, 0);
    add(PU,         16'h0000, 16'h0004, 0, 0, 0, 0, 1, 0, 0);
    add(PU,         16'h0000, 16'h0004, 0, 0, 0, 0, 1, 0, 1);
    add(NO,         16'h0000, 16'h0004, 0, 0, 0, 0, 1, 0, 0);
    add(PO,         16'h0000, 16'h0004, 0, 0, 0, 0, 0, 0, 0);
    add(PO,         16'h0000, 16'h0003, 0, 0, 0, 0, 0, 0, 0);
    add(PO,         16'h0000, 16'h0002, 0, 0, 0, 0, 0, 0, 0);
    add(PO,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1, 0);
    // pop when empty blocks the inc
    add(PO | IN,    16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1, 1);
    add(LD,         16'h0007, 16'h0007, 0, 0, 0, 0, 0, 1, 0);
    add(PU | LD,    16'h0008, 16'h0008, 0, 0, 0, 0, 0, 0, 0);
    add(PU | LD,    16'h0009, 16'h0009, 0, 0, 0, 0, 0, 0, 0);
    add(PU | PO,    16'h0000, 16'h0009, 0, 0, 0, 0, 0, 0, 1);
    add(PO,         16'h0000, 16'h0008, 0, 0, 0, 0, 0, 0, 0);
    add(LD,         16'h0005, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    add(PU | IN,    16'h0000, 16'h0006, 0, 0, 0, 0, 0, 0, 0);
    add(PO,         16'h0000, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    add(PU,         16'h0000, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    add(PU,         16'h0000, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    add(R | PO | IN,16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1, 0);
    add(PO,         16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1, 1);
    add(IN,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1, 0);
    add(PU,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    // load shadows the pop: stack untouched
    add(LD | PO,    16'h00AA, 16'h00AA, 0, 0, 0, 0, 0, 0, 0);
    add(PO,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1, 0);
    add(PO,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1, 1);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].alu);
      step();
      chk("ac_out",      i, ac_w,         vecs[i].ac);
      chk("carry",       i, 16'(c_w),     16'(vecs[i].c));
      chk("ovf",         i, 16'(o_w),     16'(vecs[i].o));
      chk("zero",        i, 16'(z_w),     16'(vecs[i].z));
      chk("neg",         i, 16'(n_w),     16'(vecs[i].n));
      chk("stack_full",  i, 16'(f_w),     16'(vecs[i].f));
      chk("stack_empty", i, 16'(e_w),     16'(vecs[i].e));
      chk("stack_err",   i, 16'(err_w),   16'(vecs[i].err));
    end

    // Saturating instance: clamps at both ends, carry still flags the clamp.
    drive(LD, 16'hFFFF); step();
    drive(IN, 16'h0000); step();
    chk("sat_inc_ac",    100, ac_s,       16'hFFFF);
    chk("sat_inc_carry", 100, 16'(c_s),   16'h0001);
    chk("sat_inc_ovf",   100, 16'(o_s),   16'h0000);
    chk("wrap_inc_ac",   100, ac_w,       16'h0000);
    drive(LD, 16'h0000); step();
    drive(DE, 16'h0000); step();
    chk("sat_dec_ac",    101, ac_s,       16'h0000);
    chk("sat_dec_carry", 101, 16'(c_s),   16'h0001);
    chk("sat_dec_zero",  101, 16'(z_s),   16'h0001);
    chk("wrap_dec_ac",   101, ac_w,       16'hFFFF);
    drive(LD, 16'h7FFF); step();
    drive(IN, 16'h0000); step();
    chk("sat_ovf_ac",    102, ac_s,       16'h8000);
    chk("sat_ovf_ovf",   102, 16'(o_s),   16'h0001);
    chk("sat_ovf_carry", 102, 16'(c_s),   16'h0000);
    drive(NO, 16'h0000); step();
    chk("sat_hold_ac",   103, ac_s,       16'h8000);
    chk("sat_hold_ovf",  103, 16'(o_s),   16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
